// File: rtl/mmss_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : mmss_display_driver
//  Description : Stopwatch display back-end. Captures binary minutes/seconds,
//                converts each to two BCD digits with a sequential
//                shift-add-3 (double-dabble) engine, and drives a 4-digit
//                time-multiplexed common-anode 7-segment display.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                minutes  - binary minutes (clamped to 99 for display)
//                seconds  - binary seconds (clamped to 59 for display)
//                blank    - forces all segments and digits off
//                seg      - segment drive {g,f,e,d,c,b,a}, active-low, registered
//                dig_en   - digit enables, active-low one-hot, registered
//                busy     - high while a conversion is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module mmss_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] dig_en,
    output logic       busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CONV = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;

    localparam int                 c_CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

    logic [1:0]         r_state;
    logic [7:0]         r_min_cap;
    logic [5:0]         r_sec_cap;
    logic [7:0]         r_min_sh;
    logic [7:0]         r_sec_sh;
    logic [7:0]         r_min_bcd;
    logic [7:0]         r_sec_bcd;
    logic [2:0]         r_iter;
    logic [3:0]         r_dig [4];
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;

    logic [7:0]         w_min_clamp;
    logic [7:0]         w_sec_clamp;
    logic [7:0]         w_min_adj;
    logic [7:0]         w_sec_adj;
    logic [3:0]         w_cur_digit;
    logic [3:0]         w_onehot;

    // Add 3 to every BCD nibble that is 5 or more, so the following left
    // shift carries correctly into the next decimal place.
    function automatic logic [7:0] dabble_adjust(input logic [7:0] bcd);
        logic [7:0] res;
        res = bcd;
        if (bcd[3:0] >= 4'd5) res[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) res[7:4] = bcd[7:4] + 4'd3;
        return res;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    assign w_min_clamp = (minutes > 8'd99) ? 8'd99 : minutes;
    assign w_sec_clamp = (seconds > 6'd59) ? 8'd59 : {2'b00, seconds};
    assign w_min_adj   = dabble_adjust(r_min_bcd);
    assign w_sec_adj   = dabble_adjust(r_sec_bcd);
    assign w_cur_digit = r_dig[r_idx];
    assign w_onehot    = 4'b0001 << r_idx;
    assign busy        = (r_state != c_IDLE);

    // Capture / conversion FSM. The compare uses the raw inputs so that a
    // change between two out-of-range values still triggers a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_min_cap <= '0;
            r_sec_cap <= '0;
            r_min_sh  <= '0;
            r_sec_sh  <= '0;
            r_min_bcd <= '0;
            r_sec_bcd <= '0;
            r_iter    <= '0;
            r_dig[0]  <= '0;
            r_dig[1]  <= '0;
            r_dig[2]  <= '0;
            r_dig[3]  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if ({minutes, seconds} != {r_min_cap, r_sec_cap}) begin
                        r_min_cap <= minutes;
                        r_sec_cap <= seconds;
                        r_min_sh  <= w_min_clamp;
                        r_sec_sh  <= w_sec_clamp;
                        r_min_bcd <= '0;
                        r_sec_bcd <= '0;
                        r_iter    <= '0;
                        r_state   <= c_CONV;
                    end
                end
                c_CONV: begin
                    // Shift the adjusted BCD and the binary operand as one
                    // 16-bit register; the binary MSB enters the BCD LSB.
                    {r_min_bcd, r_min_sh} <= {w_min_adj, r_min_sh} << 1;
                    {r_sec_bcd, r_sec_sh} <= {w_sec_adj, r_sec_sh} << 1;
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_dig[0] <= r_sec_bcd[3:0];
                    r_dig[1] <= r_sec_bcd[7:4];
                    r_dig[2] <= r_min_bcd[3:0];
                    r_dig[3] <= r_min_bcd[7:4];
                    r_state  <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Refresh timing and output registers. These run independently of the
    // converter, so a LOAD never disturbs the multiplex phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            seg    <= 7'h40;
            dig_en <= 4'hE;
        end else begin
            if (r_cnt == c_CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (blank) begin
                seg    <= 7'h7F;
                dig_en <= 4'hF;
            end else begin
                seg    <= seg_decode(w_cur_digit);
                dig_en <= ~w_onehot;
            end
        end
    end

endmodule
`default_nettype wire
